// File: rtl/note_chart_streamer.sv
// note_chart_streamer
//   Walks a note chart held in a synchronous block ROM and streams each note
//   record to the scoring block once the note enters the lookahead window
//   ahead of song_time. Also answers the scorer's metadata request with the
//   chart header word read from ROM address 0.
//
// Ports
//   clk              100 MHz system clock
//   reset            synchronous, active-high
//   pause            high: no new note is released (an offered note stays)
//   song_time[15:0]  current song position, ms
//   rom_addr         chart ROM address (ADDR_W bits)
//   rom_data[31:0]   ROM word, valid the cycle after rom_addr
//   metadata_request one-cycle request pulse from the scorer
//   metadata[31:0]   header {note_count[31:16], song_len_ms[15:0]}
//   metadata_valid   one-cycle response strobe
//   ndata[31:0]      note {note_time[31:16], fret_mask[15:11], sustain_ms[10:0]}
//   ndata_valid      note offered
//   ndata_ready      scorer accepts the note
//   chart_done       all notes delivered; sticky until reset
//   skip_count[7:0]  stale notes dropped, saturating
//
// Optional feature (macro NOTE_SKIP_EN): notes whose time lies more than
// STALE_MS behind song_time are dropped in HOLD instead of being offered, and
// counted in skip_count. Without the macro every note is offered and
// skip_count is tied to zero.
//
// Handshake: ndata_valid/ndata_ready follow strict valid/ready rules. Once
// ndata_valid rises, ndata is held stable and valid stays high until a cycle
// in which ndata_ready is also high; that cycle is the transfer, and valid
// drops on the following cycle. Neither pause nor song_time withdraws an
// offered note.
module note_chart_streamer #(
  parameter int ADDR_W       = 12,
  parameter int LOOKAHEAD_MS = 2000,
  parameter int STALE_MS     = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic [15:0]       song_time,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              metadata_request,
  output logic [31:0]       metadata,
  output logic              metadata_valid,
  output logic [31:0]       ndata,
  output logic              ndata_valid,
  input  logic              ndata_ready,
  output logic              chart_done,
  output logic [7:0]        skip_count
);

`ifdef NOTE_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam int MAX_IDX = (1 << ADDR_W) - 1;

  typedef enum logic [2:0] {
    HDR_RD,
    HDR_WAIT,
    FETCH,
    FWAIT,
    HOLD,
    PRESENT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] n_notes;
  logic [ADDR_W-1:0] hdr_n;
  logic              pending;
  logic              last_note;
  logic              in_window;
  logic              stale;
  logic              drop;
  logic              advance;
  logic [16:0]       note_time_x;
  logic [16:0]       song_time_x;

  // Note count from the header word, clamped to the addressable note range.
  always_comb begin
    hdr_n = ADDR_W'(rom_data[31:16]);
    if ({16'b0, rom_data[31:16]} > 32'(MAX_IDX)) begin
      hdr_n = ADDR_W'(MAX_IDX);
    end
  end

  // Window and staleness compares are done in 17 bits so that
  // song_time + LOOKAHEAD_MS and note_time + STALE_MS never wrap.
  assign note_time_x = {1'b0, ndata[31:16]};
  assign song_time_x = {1'b0, song_time};
  assign in_window   = note_time_x <= (song_time_x + 17'(LOOKAHEAD_MS));
  assign stale       = SKIP_EN && ((note_time_x + 17'(STALE_MS)) < song_time_x);
  assign last_note   = (index == n_notes);

  // A paused streamer is frozen: it neither releases nor drops notes.
  assign drop    = (state == HOLD) && !pause && stale;
  assign advance = drop || ((state == PRESENT) && ndata_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR_RD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR_RD:   state_next = HDR_WAIT;
      HDR_WAIT: state_next = (hdr_n == '0) ? DONE : FETCH;
      FETCH:    state_next = FWAIT;
      FWAIT:    state_next = HOLD;
      HOLD: begin
        if (drop) begin
          state_next = last_note ? DONE : FETCH;
        end else if (!pause && in_window) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ndata_ready) begin
          state_next = last_note ? DONE : FETCH;
        end
      end
      DONE:     state_next = DONE;
      default:  state_next = HDR_RD;
    endcase
  end

  // Address is only meaningful in HDR_RD (header) and FETCH (note); the ROM
  // returns the word one cycle later, in HDR_WAIT / FWAIT.
  assign rom_addr    = (state == FETCH) ? index : '0;
  assign ndata_valid = (state == PRESENT);
  assign chart_done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      metadata       <= '0;
      metadata_valid <= 1'b0;
      pending        <= 1'b0;
      ndata          <= '0;
      index          <= ADDR_W'(1);
      n_notes        <= '0;
    end else begin
      metadata_valid <= 1'b0;
      case (state)
        HDR_RD: begin
          if (metadata_request) begin
            pending <= 1'b1;
          end
        end
        HDR_WAIT: begin
          metadata <= rom_data;
          n_notes  <= hdr_n;
          // Early requests are answered right after the header lands.
          if (pending || metadata_request) begin
            metadata_valid <= 1'b1;
          end
          pending <= 1'b0;
        end
        default: begin
          // A request that coincides with a response strobe is absorbed.
          if (metadata_request && !metadata_valid) begin
            metadata_valid <= 1'b1;
          end
        end
      endcase

      if (state == FWAIT) begin
        ndata <= rom_data;
      end

      if (advance && !last_note) begin
        index <= index + ADDR_W'(1);
      end
    end
  end

`ifdef NOTE_SKIP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_count <= '0;
    end else if (drop && (skip_count != 8'hFF)) begin
      skip_count <= skip_count + 8'd1;
    end
  end
`else
  assign skip_count = '0;
`endif

endmodule

// File: tb/tb_note_chart_streamer.sv
// Testbench for note_chart_streamer: a synchronous ROM model holds each chart,
// and every scenario task compares DUT outputs with values worked out from the
// chart contents and the lookahead/stale rules.
module tb_note_chart_streamer;

  localparam int LOOKAHEAD = 2000;
  localparam int STALE     = 200;
`ifdef NOTE_SKIP_EN
  localparam bit SKIP_MODEL = 1'b1;
`else
  localparam bit SKIP_MODEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic [15:0] song_time;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        metadata_request;
  logic [31:0] metadata;
  logic        metadata_valid;
  logic [31:0] ndata;
  logic        ndata_valid;
  logic        ndata_ready;
  logic        chart_done;
  logic [7:0]  skip_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:4095];
  logic [31:0] exp_q[$];

  note_chart_streamer dut (
    .clk              (clk),
    .reset            (reset),
    .pause            (pause),
    .song_time        (song_time),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .metadata_request (metadata_request),
    .metadata         (metadata),
    .metadata_valid   (metadata_valid),
    .ndata            (ndata),
    .ndata_valid      (ndata_valid),
    .ndata_ready      (ndata_ready),
    .chart_done       (chart_done),
    .skip_count       (skip_count)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- driver helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
  endtask

  function automatic logic [31:0] make_note(input int t);
    logic [15:0] tt;
    logic [4:0]  fret;
    logic [10:0] sus;
    tt   = 16'(t);
    fret = 5'($urandom_range(0, 31));
    sus  = 11'($urandom_range(0, 2047));
    return {tt, fret, sus};
  endfunction

  // Leaves the bench at a negedge with reset just released: the coming
  // cycle is the first one in HDR_RD.
  task automatic apply_reset();
    reset            = 1'b1;
    metadata_request = 1'b0;
    ndata_ready      = 1'b0;
    pause            = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; song_time = '0;
    metadata_request = 1'b0; ndata_ready = 1'b0;
    clear_rom();
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 12'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    checks++; if (metadata !== 32'h0) begin errors++; $display("FAIL reset_metadata: got %h expected 0", metadata); end
    checks++; if (metadata_valid !== 1'b0) begin errors++; $display("FAIL reset_metadata_valid: got %b expected 0", metadata_valid); end
    checks++; if (ndata !== 32'h0) begin errors++; $display("FAIL reset_ndata: got %h expected 0", ndata); end
    checks++; if (ndata_valid !== 1'b0) begin errors++; $display("FAIL reset_ndata_valid: got %b expected 0", ndata_valid); end
    checks++; if (chart_done !== 1'b0) begin errors++; $display("FAIL reset_chart_done: got %b expected 0", chart_done); end
    checks++; if (skip_count !== 8'h0) begin errors++; $display("FAIL reset_skip_count: got %0d expected 0", skip_count); end
  endtask

  task automatic test_basic_chart();
    logic [31:0] hdr;
    logic [31:0] want;
    int strobes, first_strobe, accepts, late_strobes;
    hdr = 32'h0003_7530;
    clear_rom();
    rom[0] = hdr;
    rom[1] = make_note(1000);
    rom[2] = make_note(1500);
    rom[3] = make_note(4000);
    exp_q.delete();
    for (int i = 1; i <= 3; i++) exp_q.push_back(rom[i]);
    song_time = '0;
    apply_reset();
    metadata_request = 1'b1;
    ndata_ready      = 1'b1;
    strobes = 0; first_strobe = -1; accepts = 0;
    for (int cyc = 1; cyc <= 1000 && accepts < 3; cyc++) begin
      @(negedge clk);
      metadata_request = 1'b0;
      if (metadata_valid) begin
        strobes++;
        if (first_strobe < 0) first_strobe = cyc;
        checks++;
        if (metadata !== hdr) begin errors++; $display("FAIL basic_metadata: got %h expected %h", metadata, hdr); end
      end
      if (ndata_valid) begin
        checks++;
        if (int'(ndata[31:16]) > int'(song_time) + LOOKAHEAD) begin
          errors++; $display("FAIL basic_window: note_time %0d offered at song_time %0d", ndata[31:16], song_time);
        end
        if (accepts == 0) begin
          checks++;
          if (cyc != 5) begin errors++; $display("FAIL basic_first_latency: first offer at cycle %0d expected 5", cyc); end
        end
        if (accepts == 2) begin
          checks++;
          if (song_time !== 16'd2000) begin errors++; $display("FAIL basic_note3_time: offered at song_time %0d expected 2000", song_time); end
        end
        want = exp_q.pop_front();
        checks++;
        if (ndata !== want) begin errors++; $display("FAIL basic_ndata: got %h expected %h", ndata, want); end
        accepts++;
      end
      song_time = song_time + 16'd10;
    end
    checks++;
    if (accepts != 3) begin errors++; $display("FAIL basic_timeout: accepted %0d notes expected 3", accepts); end
    @(negedge clk);
    checks++;
    if (chart_done !== 1'b1 || ndata_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done: chart_done %b ndata_valid %b expected 1 0", chart_done, ndata_valid);
    end
    checks++;
    if (strobes != 1 || first_strobe != 2) begin
      errors++; $display("FAIL basic_strobe: %0d strobes first at cycle %0d expected 1 at cycle 2", strobes, first_strobe);
    end
    // Request held for two cycles in DONE: the second cycle overlaps the strobe.
    metadata_request = 1'b1;
    late_strobes = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (metadata_valid) late_strobes++;
      if (cyc == 1) metadata_request = 1'b0;
    end
    checks++;
    if (late_strobes != 1) begin errors++; $display("FAIL done_request_strobes: got %0d expected 1", late_strobes); end
    checks++;
    if (metadata !== hdr || chart_done !== 1'b1) begin
      errors++; $display("FAIL done_state_hold: metadata %h chart_done %b expected %h 1", metadata, chart_done, hdr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic        seen;
    int          gap;
    clear_rom();
    rom[0] = {16'd2, 16'd900};
    rom[1] = make_note(0);
    rom[2] = make_note(100);
    song_time = '0;
    apply_reset();
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (ndata_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_offer_timeout: ndata_valid %b expected 1", ndata_valid); end
    held = ndata;
    checks++;
    if (held !== rom[1]) begin errors++; $display("FAIL bp_first_note: got %h expected %h", held, rom[1]); end
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc >= 10) pause = ~pause;
      @(negedge clk);
      checks++;
      if (ndata_valid !== 1'b1 || ndata !== held) begin
        errors++; $display("FAIL bp_hold: cycle %0d valid %b ndata %h expected 1 %h", cyc, ndata_valid, ndata, held);
      end
    end
    pause = 1'b0;
    ndata_ready = 1'b1;
    @(negedge clk);
    gap = 1;
    checks++;
    if (ndata_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: ndata_valid %b expected 0", ndata_valid); end
    while (!ndata_valid && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap < 4 || ndata !== rom[2]) begin
      errors++; $display("FAIL bp_next_note: gap %0d ndata %h expected >=4 %h", gap, ndata, rom[2]);
    end
    @(negedge clk);
    checks++;
    if (chart_done !== 1'b1) begin errors++; $display("FAIL bp_done: chart_done %b expected 1", chart_done); end
  endtask

  task automatic test_empty_chart();
    int vcount;
    clear_rom();
    rom[0] = {16'd0, 16'd1234};
    rom[1] = make_note(0);
    song_time = '0;
    apply_reset();
    ndata_ready = 1'b1;
    vcount = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (ndata_valid) vcount++;
      if (cyc == 2) begin
        checks++;
        if (chart_done !== 1'b1) begin errors++; $display("FAIL empty_done_latency: chart_done %b expected 1", chart_done); end
        checks++;
        if (metadata !== rom[0]) begin errors++; $display("FAIL empty_metadata: got %h expected %h", metadata, rom[0]); end
      end
    end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL empty_no_offer: %0d valid cycles expected 0", vcount); end
    checks++;
    if (chart_done !== 1'b1) begin errors++; $display("FAIL empty_done_sticky: chart_done %b expected 1", chart_done); end
  endtask

  task automatic test_reset_mid_handshake();
    logic [31:0] hdr;
    logic [86:0] obs;
    logic        seen;
    hdr = {16'd3, 16'd777};
    clear_rom();
    rom[0] = hdr;
    rom[1] = make_note(0);
    rom[2] = make_note(10);
    rom[3] = make_note(20);
    song_time = '0;
    apply_reset();
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (ndata_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || ndata !== rom[1]) begin errors++; $display("FAIL rm_note1: valid %b ndata %h expected 1 %h", seen, ndata, rom[1]); end
    ndata_ready = 1'b1;
    @(negedge clk);
    ndata_ready = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (ndata_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || ndata !== rom[2]) begin errors++; $display("FAIL rm_note2: valid %b ndata %h expected 1 %h", seen, ndata, rom[2]); end
    reset = 1'b1;
    @(negedge clk);
    obs = {rom_addr, metadata, metadata_valid, ndata, ndata_valid, chart_done, skip_count};
    checks++;
    if (obs !== 87'h0) begin errors++; $display("FAIL rm_outputs_cleared: got %h expected 0", obs); end
    reset = 1'b0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (metadata !== hdr) begin errors++; $display("FAIL rm_header_reread: got %h expected %h", metadata, hdr); end
      end
      if (ndata_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || ndata !== rom[1]) begin errors++; $display("FAIL rm_note1_again: valid %b ndata %h expected 1 %h", seen, ndata, rom[1]); end
  endtask

  task automatic test_stale();
    int          stale_n, exp_skip, t;
    logic        fin;
    logic [31:0] want;
    clear_rom();
    rom[0] = {16'd263, 16'd9000};
    for (int i = 1; i <= 260; i++) rom[i] = make_note(4000);
    rom[261] = make_note(5000);
    rom[262] = make_note(6000);
    rom[263] = make_note(7000);
    exp_q.delete();
    stale_n = 0;
    for (int i = 1; i <= 263; i++) begin
      t = int'(rom[i][31:16]);
      if (SKIP_MODEL && (t + STALE < 5000)) stale_n++;
      else exp_q.push_back(rom[i]);
    end
    exp_skip = (stale_n > 255) ? 255 : stale_n;
    song_time = 16'd5000;
    apply_reset();
    ndata_ready = 1'b1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      if (chart_done) fin = 1'b1;
      else if (ndata_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stale_extra_note: got %h expected none", ndata);
        end else begin
          want = exp_q.pop_front();
          if (ndata !== want) begin errors++; $display("FAIL stale_ndata: got %h expected %h", ndata, want); end
        end
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL stale_timeout: chart_done %b expected 1", chart_done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stale_missing: %0d notes not offered expected 0", exp_q.size()); end
    checks++;
    if (int'(skip_count) != exp_skip) begin errors++; $display("FAIL stale_skip_count: got %0d expected %0d", skip_count, exp_skip); end
  endtask

  task automatic test_random();
    int          n, t;
    logic        fin, prev_valid, prev_hold;
    logic [31:0] prev_data, want;
    n = $urandom_range(5, 40);
    clear_rom();
    rom[0] = {16'(n), 16'($urandom_range(0, 65535))};
    exp_q.delete();
    t = $urandom_range(0, 3000);
    for (int i = 1; i <= n; i++) begin
      rom[i] = make_note(t);
      exp_q.push_back(rom[i]);
      t = t + $urandom_range(50, 300);
    end
    song_time = '0;
    apply_reset();
    fin = 1'b0; prev_valid = 1'b0; prev_hold = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (ndata_valid !== 1'b1 || ndata !== prev_data) begin
          errors++; $display("FAIL rand_stable: valid %b ndata %h expected 1 %h", ndata_valid, ndata, prev_data);
        end
      end
      if (ndata_valid && !prev_valid) begin
        checks++;
        if (int'(ndata[31:16]) > int'(song_time) + LOOKAHEAD) begin
          errors++; $display("FAIL rand_window: note_time %0d offered at song_time %0d", ndata[31:16], song_time);
        end
      end
      if (chart_done) fin = 1'b1;
      ndata_ready = ($urandom_range(0, 3) != 0);
      pause       = ($urandom_range(0, 7) == 0);
      if (ndata_valid && ndata_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_note: got %h expected none", ndata);
        end else begin
          want = exp_q.pop_front();
          if (ndata !== want) begin errors++; $display("FAIL rand_ndata: got %h expected %h", ndata, want); end
        end
      end
      prev_hold  = ndata_valid && !ndata_ready;
      prev_valid = ndata_valid;
      prev_data  = ndata;
      song_time  = song_time + 16'd4;
    end
    pause = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL rand_timeout: chart_done %b expected 1", chart_done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing: %0d notes not delivered expected 0", exp_q.size()); end
    checks++;
    if (skip_count !== 8'h0) begin errors++; $display("FAIL rand_skip_count: got %0d expected 0", skip_count); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_chart();
    test_backpressure();
    test_empty_chart();
    test_reset_mid_handshake();
    test_stale();
    repeat (3) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
